id_ex_issue_stage: RTL and testbench
====================================

// Module: id_ex_issue_stage
// PURPOSE
//  Decode/issue stage directly downstream of the 8x8-bit register file.
//  - Drives the register-file read addresses and receives the read data.
//  - Resolves RAW hazards by forwarding from MEM/WB, or by interlocking for one cycle.
//  - Registers the ID/EX pipeline state that feeds the ALU stage.
//  - Supports stall, flush and a stall-cycle performance counter.
// PARAMETERS
//  DATA_W  8   operand / result width
//  ADDR_W  3   register address width (8 registers, r0 hard-wired to zero)
//  CTRL_W  6   opaque ALU/memory control bundle, passed through unchanged
//  CNT_W   16  width of the stall-cycle counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous, active-low reset
//  id_valid      in   1       decoded instruction is present
//  id_ready      out  1       stage accepts the instruction this cycle
//  id_rs/id_rt   in   ADDR_W  source registers
//  id_rd         in   ADDR_W  destination register
//  id_reg_write  in   1       instruction writes id_rd
//  id_imm        in   DATA_W  immediate
//  id_ctrl       in   CTRL_W  control bundle
//  rf_addr_A/B   out  ADDR_W  register-file read addresses (combinational = id_rs/id_rt)
//  rf_data_A/B   in   DATA_W  register-file read data
//  mem_reg_write in   1       MEM-stage instruction writes a register
//  mem_rd        in   ADDR_W  MEM-stage destination
//  mem_result    in   DATA_W  MEM-stage final value (ALU result or load data)
//  wb_reg_write  in   1       WB-stage write enable (same signal drives reg_write)
//  wb_rd         in   ADDR_W  WB-stage destination
//  wb_data       in   DATA_W  WB-stage write data
//  ex_stall      in   1       EX stage cannot accept; hold the ID/EX registers
//  flush         in   1       kill the instruction being issued (branch taken)
//  ex_valid      out  1       ID/EX holds a live instruction
//  ex_opA/ex_opB out  DATA_W  resolved operands
//  ex_imm        out  DATA_W  registered immediate
//  ex_rd         out  ADDR_W  registered destination
//  ex_reg_write  out  1       registered write enable
//  ex_ctrl       out  CTRL_W  registered control bundle
//  stall_count   out  CNT_W   saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (asynchronous, any time, including mid-stall): all ex_* outputs = 0, stall_count = 0.
//  - Latency: one cycle from accept (id_valid & id_ready) to ex_valid = 1.
//  - hazard_ex: ex_valid & ex_reg_write & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt).
//  - id_ready = !ex_stall & !hazard (and !hazard_wb when the WB bypass is compiled out).
//  - Each posedge applies the first matching case:
//    1. flush: ex_valid <= 0. Wins over ex_stall and hazard. Other ex_* may hold.
//    2. ex_stall: hold all ex_* registers.
//    3. hazard & id_valid: insert a bubble (ex_valid <= 0); stall_count += 1, saturating at all-ones.
//    4. otherwise: ex_valid <= id_valid; capture resolved operands and id_* fields.
//  - Operand resolution, per source s:
//    - s == 0 -> 0.
//    - else mem_reg_write & mem_rd == s -> mem_result.
//    - else WB match (see CONFIGURATION).
//    - else rf_data.
//  - MEM has priority over WB. Writes targeting r0 never forward and never cause a hazard.
//  - A hazard lasts exactly one cycle: the producer advances to MEM and is then forwarded.
//  - In the hazard cycle, ex_stall = 1 keeps the stage in case 2 (hold). The counter counts only bubbles actually inserted.
// CONFIGURATION
//  - Macro: ID_EX_WB_BYPASS_EN. Needed because the register file writes at the posedge, so a same-cycle read returns stale data.
//  - Defined: wb_reg_write & wb_rd == s (s != 0) -> wb_data, with no stall.
//  - Undefined: that match raises hazard_wb, giving a one-cycle bubble that is counted in stall_count. The re-read then returns the written value.
// STRUCTURE
//  - Package mips_pipe_pkg holds:
//    - the DATA_W, ADDR_W and CTRL_W defaults;
//    - the REG_ZERO constant;
//    - the fwd_sel_t enum {FWD_RF, FWD_MEM, FWD_WB, FWD_ZERO};
//    - the ctrl bit-field index constants.
//  - Sub-module operand_fwd_mux (source address, RF/MEM/WB inputs -> sel, value) is instantiated twice.
//  - Hazard logic, pipeline registers and the counter live in the top level.
// TESTING
//  - Reset: drive rst_n = 0 mid-stall -> ex_valid = 0, ex_opA = 0, stall_count = 0 immediately; id_ready = 1 after release.
//  - RAW on EX: issue rd = 3 (writes), then rs = 3.
//    -> id_ready = 0 for 1 cycle, one bubble, stall_count = 1.
//    -> Next cycle, with mem_rd = 3 and mem_result = 0x2A: ex_opA = 0x2A.
//  - Priority: mem_rd = wb_rd = 2, mem_result = 0x11, wb_data = 0x22, rs = 2 -> ex_opA = 0x11.
//  - r0: mem_reg_write = 1, mem_rd = 0, mem_result = 0xFF, rs = rt = 0 -> ex_opA = ex_opB = 0x00, no stall.
//  - WB bypass: wb_rd = 5, wb_data = 0x5A, rf_data_B = 0x00, rt = 5.
//    -> With ID_EX_WB_BYPASS_EN: ex_opB = 0x5A, no stall.
//    -> Without it: one bubble, then ex_opB = 0x5A from the register file.
//  - flush together with ex_stall -> ex_valid = 0 next cycle, stall_count unchanged.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared widths, forwarding selects and control-field indices for the MIPS pipeline.
// Build option ID_EX_WB_BYPASS_EN enables the WB->ID operand bypass.
package mips_pipe_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 6;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_t;

  localparam int CTRL_ALU_LSB = 0;
  localparam int CTRL_ALU_MSB = 3;
  localparam int CTRL_MEM_RD  = 4;
  localparam int CTRL_MEM_WR  = 5;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-source operand resolution: r0, MEM forward, WB match or register file.
// ID_EX_WB_BYPASS_EN selects wb_data on a WB match; otherwise the match only reports FWD_WB.
module operand_fwd_mux #(
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int ADDR_W = mips_pipe_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]      src,
  input  logic [DATA_W-1:0]      rf_data,
  input  logic                   mem_reg_write,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic                   wb_reg_write,
  input  logic [ADDR_W-1:0]      wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  output mips_pipe_pkg::fwd_sel_t sel,
  output logic [DATA_W-1:0]      value
);

  import mips_pipe_pkg::*;

  logic is_zero;
  logic mem_hit;
  logic wb_hit;

  assign is_zero = (src == REG_ZERO);
  assign mem_hit = mem_reg_write && (mem_rd == src) && !is_zero;
  assign wb_hit  = wb_reg_write && (wb_rd == src) && !is_zero && !mem_hit;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      is_zero: sel = FWD_ZERO;
      mem_hit: sel = FWD_MEM;
      wb_hit:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

  always_comb begin
    value = rf_data;
    unique case (sel)
      FWD_ZERO: value = '0;
      FWD_MEM:  value = mem_result;
`ifdef ID_EX_WB_BYPASS_EN
      FWD_WB:   value = wb_data;
`else
      FWD_WB:   value = rf_data;
`endif
      default:  value = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_issue_stage.sv
// ID/EX issue stage: operand forwarding, one-cycle RAW interlock, stall/flush, stall counter.
// Build option ID_EX_WB_BYPASS_EN removes the WB-match interlock in favour of a bypass.
module id_ex_issue_stage #(
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int ADDR_W = mips_pipe_pkg::ADDR_W,
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [ADDR_W-1:0] rf_addr_A,
  output logic [ADDR_W-1:0] rf_addr_B,
  input  logic [DATA_W-1:0] rf_data_A,
  input  logic [DATA_W-1:0] rf_data_B,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  import mips_pipe_pkg::*;

  fwd_sel_t          sel_a, sel_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              hazard_ex, hazard_wb, hazard;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_opa_q, ex_opa_d;
  logic [DATA_W-1:0] ex_opb_q, ex_opb_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign rf_addr_A = id_rs;
  assign rf_addr_B = id_rt;

  operand_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .src          (id_rs),
    .rf_data      (rf_data_A),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .sel          (sel_a),
    .value        (op_a)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .src          (id_rt),
    .rf_data      (rf_data_B),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .sel          (sel_b),
    .value        (op_b)
  );

  assign hazard_ex = ex_valid_q && ex_rw_q
                  && (ex_rd_q != REG_ZERO)
                  && ((ex_rd_q == id_rs) || (ex_rd_q == id_rt));

`ifdef ID_EX_WB_BYPASS_EN
  assign hazard_wb = 1'b0;
`else
  // RF writes at the same edge, so a WB match would read stale data
  assign hazard_wb = (sel_a == FWD_WB) || (sel_b == FWD_WB);
`endif

  assign hazard   = hazard_ex || hazard_wb;
  assign id_ready = !ex_stall && !hazard;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_opa_d   = ex_opa_q;
    ex_opb_d   = ex_opb_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_rw_d    = ex_rw_q;
    ex_ctrl_d  = ex_ctrl_q;
    cnt_d      = cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_stall) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard && id_valid) begin
      ex_valid_d = 1'b0;
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else begin
      ex_valid_d = id_valid;
      ex_opa_d   = op_a;
      ex_opb_d   = op_b;
      ex_imm_d   = id_imm;
      ex_rd_d    = id_rd;
      ex_rw_d    = id_reg_write;
      ex_ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_opa_q   <= '0;
      ex_opb_q   <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_ctrl_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_opa_q   <= ex_opa_d;
      ex_opb_q   <= ex_opb_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_rw_q    <= ex_rw_d;
      ex_ctrl_q  <= ex_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_opA       = ex_opa_q;
  assign ex_opB       = ex_opb_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_rw_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Directed bench for id_ex_issue_stage with a cycle-level reference model.
// Expectations adapt to ID_EX_WB_BYPASS_EN when it is defined for the build.
module tb_id_ex_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_ready;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_reg_write;
  logic [7:0] id_imm;
  logic [5:0] id_ctrl;
  logic [2:0] rf_addr_A, rf_addr_B;
  logic [7:0] rf_data_A, rf_data_B;
  logic       mem_reg_write;
  logic [2:0] mem_rd;
  logic [7:0] mem_result;
  logic       wb_reg_write;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       ex_stall, flush;
  logic       ex_valid;
  logic [7:0] ex_opA, ex_opB, ex_imm;
  logic [2:0] ex_rd;
  logic       ex_reg_write;
  logic [5:0] ex_ctrl;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_addr_A(rf_addr_A), .rf_addr_B(rf_addr_B),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what ID/EX must hold, derived from the issue rules
  bit       m_valid = 0;
  bit       m_rw    = 0;
  bit [2:0] m_rd    = 0;
  bit [7:0] m_opa   = 0;
  bit [7:0] m_opb   = 0;
  bit [7:0] m_imm   = 0;
  bit [5:0] m_ctrl  = 0;
  int       m_cnt   = 0;

  function automatic bit [7:0] resolve(bit [2:0] s, bit [7:0] rf);
    if (s == 0) return 8'h00;
    if (mem_reg_write && mem_rd == s) return mem_result;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && wb_rd == s) return wb_data;
`endif
    return rf;
  endfunction

  function automatic bit wb_blocks(bit [2:0] s);
`ifdef ID_EX_WB_BYPASS_EN
    return 1'b0;
`else
    return s != 0 && wb_reg_write && wb_rd == s
        && !(mem_reg_write && mem_rd == s);
`endif
  endfunction

  function automatic bit m_hazard();
    bit producer;
    producer = m_valid && m_rw && m_rd != 0;
    return (producer && (m_rd == id_rs || m_rd == id_rt))
        || wb_blocks(id_rs) || wb_blocks(id_rt);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_rd = 0;
      m_opa = 0; m_opb = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (ex_stall) begin
      m_valid = m_valid;
    end else if (m_hazard() && id_valid) begin
      m_valid = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_opa   = resolve(id_rs, rf_data_A);
      m_opb   = resolve(id_rt, rf_data_B);
      m_imm   = id_imm;
      m_rd    = id_rd;
      m_rw    = id_reg_write;
      m_ctrl  = id_ctrl;
    end
  end

  always @(negedge clk) begin
    chk("ex_valid", ex_valid, m_valid);
    chk("stall_count", stall_count, m_cnt);
    chk("id_ready", id_ready, !ex_stall && !m_hazard());
    chk("rf_addr_A", rf_addr_A, id_rs);
    chk("rf_addr_B", rf_addr_B, id_rt);
    if (m_valid) begin
      chk("ex_opA", ex_opA, m_opa);
      chk("ex_opB", ex_opB, m_opb);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_reg_write", ex_reg_write, m_rw);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit [2:0] rs, bit [2:0] rt, bit [2:0] rd,
                       bit rw, bit [7:0] imm, bit [7:0] ra, bit [7:0] rb);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_imm = imm; rf_data_A = ra; rf_data_B = rb;
    id_ctrl = imm[5:0];
  endtask

  int exp_cnt;

  initial begin
    rst_n = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_reg_write = 0;
    id_imm = 0; id_ctrl = 0; rf_data_A = 0; rf_data_B = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    ex_stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1 chk("ready_after_reset", id_ready, 1);
    cyc();

    // producer r3, then dependent rs=3: one bubble, then MEM forward
    issue(1, 2, 3, 1, 8'h33, 8'h10, 8'h20);
    cyc();
    chk("raw_prod_opA", ex_opA, 8'h10);
    chk("raw_prod_rd", ex_rd, 3);
    issue(3, 0, 4, 1, 8'h44, 8'h99, 8'h00);
    #1 chk("raw_ready", id_ready, 0);
    cyc();
    chk("raw_bubble", ex_valid, 0);
    chk("raw_count", stall_count, 1);
    mem_reg_write = 1; mem_rd = 3; mem_result = 8'h2A;
    #1 chk("raw_ready2", id_ready, 1);
    cyc();
    chk("raw_fwd_opA", ex_opA, 8'h2A);
    chk("raw_fwd_valid", ex_valid, 1);

    id_valid = 0; id_rs = 0; id_rt = 0; mem_reg_write = 0;
    cyc();
    chk("idle_valid", ex_valid, 0);

    // MEM beats WB on the same register
    issue(2, 0, 0, 0, 8'h05, 8'h33, 8'h00);
    mem_reg_write = 1; mem_rd = 2; mem_result = 8'h11;
    wb_reg_write = 1; wb_rd = 2; wb_data = 8'h22;
    cyc();
    chk("prio_opA", ex_opA, 8'h11);

    // r0 is never forwarded and never a hazard
    issue(0, 0, 0, 1, 8'h06, 8'h77, 8'h66);
    mem_reg_write = 1; mem_rd = 0; mem_result = 8'hFF; wb_reg_write = 0;
    #1 chk("r0_ready", id_ready, 1);
    cyc();
    chk("r0_opA", ex_opA, 8'h00);
    chk("r0_opB", ex_opB, 8'h00);
    issue(0, 1, 0, 0, 8'h07, 8'h01, 8'h02);
    mem_reg_write = 0;
    #1 chk("r0_nohaz", id_ready, 1);
    cyc();
    chk("r0_after_opB", ex_opB, 8'h02);
    chk("r0_count", stall_count, 1);

    // WB match on rt=5
    issue(0, 5, 6, 1, 8'h08, 8'h00, 8'h00);
    wb_reg_write = 1; wb_rd = 5; wb_data = 8'h5A;
`ifdef ID_EX_WB_BYPASS_EN
    #1 chk("wb_ready", id_ready, 1);
    cyc();
    chk("wb_opB", ex_opB, 8'h5A);
    exp_cnt = 1;
`else
    #1 chk("wb_ready", id_ready, 0);
    cyc();
    chk("wb_bubble", ex_valid, 0);
    chk("wb_count", stall_count, 2);
    wb_reg_write = 0; rf_data_B = 8'h5A;
    cyc();
    chk("wb_opB", ex_opB, 8'h5A);
    exp_cnt = 2;
`endif
    wb_reg_write = 0;
    chk("wb_valid", ex_valid, 1);

    // flush wins over stall, counter untouched
    issue(0, 0, 1, 0, 8'h09, 8'h00, 8'h00);
    ex_stall = 1; flush = 1;
    cyc();
    chk("flush_valid", ex_valid, 0);
    chk("flush_count", stall_count, exp_cnt);

    // stall holds, and holds through a hazard without counting
    ex_stall = 0; flush = 0;
    issue(0, 0, 7, 1, 8'h70, 8'h00, 8'h00);
    cyc();
    chk("hold_pre_imm", ex_imm, 8'h70);
    issue(7, 0, 1, 0, 8'h71, 8'h00, 8'h00);
    ex_stall = 1;
    #1 chk("hold_ready", id_ready, 0);
    cyc();
    chk("hold_imm", ex_imm, 8'h70);
    chk("hold_valid", ex_valid, 1);
    chk("hold_count", stall_count, exp_cnt);
    ex_stall = 0;
    cyc();
    chk("haz_bubble", ex_valid, 0);
    chk("haz_count", stall_count, exp_cnt + 1);

    // asynchronous reset in the middle of a stall
    issue(1, 0, 1, 0, 8'h12, 8'h12, 8'h00);
    cyc();
    chk("pre_rst_opA", ex_opA, 8'h12);
    ex_stall = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_opA", ex_opA, 8'h00);
    chk("rst_count", stall_count, 0);
    ex_stall = 0; id_valid = 0; id_rs = 0; id_rt = 0;
    #2 rst_n = 1;
    #1 chk("rst_ready", id_ready, 1);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
